// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
package pipe_pkg;
  localparam int OCC_W = 2;

  // Encoding equals the number of held entries, so the state doubles as occupancy.
  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_entry_reg.sv
// One payload entry: loadable register with reset and a masked clear on flush.
module pipe_entry_reg import pipe_pkg::*; #(
  parameter int                DATA_W     = 256,
  parameter logic [DATA_W-1:0] CLEAR_MASK = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= q & ~CLEAR_MASK;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a one-entry skid buffer; in_ready is registered.
//
// state | meaning
// EMPTY | no entry held; out_valid=0
// ONE   | main entry valid and presented on out_data
// TWO   | main and skid valid; upstream stalled (in_ready=0)
module pipe_skid_stage import pipe_pkg::*; #(
  parameter int                DATA_W     = 256,
  parameter logic [DATA_W-1:0] CLEAR_MASK = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy
);

  state_t            state, state_nxt;
  logic              accept, emit;
  logic              load_main, load_skid, main_from_skid;
  logic [DATA_W-1:0] main_d, skid_q;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;
  assign main_d = main_from_skid ? skid_q : in_data;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (emit) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            state_nxt      = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs are registered from the next state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
      occupancy <= state_nxt;
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .CLEAR_MASK(CLEAR_MASK)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (load_main),
    .flush (flush),
    .d     (main_d),
    .q     (out_data)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CLEAR_MASK(CLEAR_MASK)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (load_skid),
    .flush (flush),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboarded random checks of pipe_skid_stage (DATA_W=16, CLEAR_MASK=16'h00FF).
module tb_pipe_skid_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flush;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(16), .CLEAR_MASK(16'h00FF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic acc, em;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_bit ("rst_in_ready", in_ready, 1'b1);
    chk_bit ("rst_out_valid", out_valid, 1'b0);
    chk_word("rst_out_data", out_data, 16'h0000);
    chk_occ ("rst_occ", occupancy, 2'd0);

    // Single transfer, one-cycle latency
    in_valid = 1'b1; in_data = 16'hA501;
    step();
    in_valid = 1'b0;
    chk_bit ("lat_out_valid", out_valid, 1'b1);
    chk_word("lat_out_data", out_data, 16'hA501);
    chk_occ ("lat_occ", occupancy, 2'd1);
    out_ready = 1'b1;
    step();
    chk_bit ("drain_out_valid", out_valid, 1'b0);
    out_ready = 1'b0;

    // Backpressure fills the skid, then drains in order
    in_valid = 1'b1; in_data = 16'h1111;
    step();
    chk_occ ("bp1_occ", occupancy, 2'd1);
    chk_bit ("bp1_in_ready", in_ready, 1'b1);
    in_data = 16'h2222;
    step();
    chk_occ ("bp2_occ", occupancy, 2'd2);
    chk_bit ("bp2_in_ready", in_ready, 1'b0);
    chk_word("bp2_out_data", out_data, 16'h1111);
    in_data = 16'h3333;
    step();
    chk_occ ("hold_occ", occupancy, 2'd2);
    chk_word("hold_out_data", out_data, 16'h1111);
    chk_bit ("hold_out_valid", out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_word("drain1_out_data", out_data, 16'h2222);
    chk_bit ("drain1_in_ready", in_ready, 1'b1);
    chk_occ ("drain1_occ", occupancy, 2'd1);
    step();
    chk_bit ("drain2_out_valid", out_valid, 1'b0);
    chk_occ ("drain2_occ", occupancy, 2'd0);

    // Full throughput
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'(i);
      step();
      chk_word("stream_out_data", out_data, 16'(i));
      chk_bit ("stream_out_valid", out_valid, 1'b1);
      chk_occ ("stream_occ", occupancy, 2'd1);
    end
    in_valid = 1'b0;
    step();
    chk_occ ("stream_end_occ", occupancy, 2'd0);

    // Flush from TWO with a concurrent offer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hABCD;
    step();
    in_data = 16'h1234;
    step();
    chk_occ ("pre_flush_occ", occupancy, 2'd2);
    flush = 1'b1; in_data = 16'h5555;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_bit ("flush_out_valid", out_valid, 1'b0);
    chk_occ ("flush_occ", occupancy, 2'd0);
    chk_bit ("flush_in_ready", in_ready, 1'b1);
    chk_word("flush_skid", dut.u_skid.q, 16'h1200);
    chk_word("flush_main", out_data, 16'hAB00);
    out_ready = 1'b1;
    step();
    chk_bit ("flush_no_emit", out_valid, 1'b0);

    // Reset while in TWO, with handshakes and flush ignored
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h7777;
    step();
    in_data = 16'h8888;
    step();
    chk_occ ("pre_rst_occ", occupancy, 2'd2);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    step();
    chk_bit ("rst2_in_ready", in_ready, 1'b1);
    chk_bit ("rst2_out_valid", out_valid, 1'b0);
    chk_word("rst2_out_data", out_data, 16'h0000);
    chk_occ ("rst2_occ", occupancy, 2'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Random traffic against a queue scoreboard
    sb_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = 16'($urandom);
      chk_bit("rnd_out_valid", out_valid, sb_q.size() != 0);
      chk_bit("rnd_in_ready", in_ready, sb_q.size() < 2);
      chk_occ("rnd_occ", occupancy, 2'(sb_q.size()));
      acc = in_valid && (sb_q.size() < 2);
      em  = out_ready && (sb_q.size() != 0);
      if (em) begin
        chk_word("rnd_out_data", out_data, sb_q[0]);
        void'(sb_q.pop_front());
      end
      if (flush) sb_q.delete();
      else if (acc) sb_q.push_back(in_data);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 256, meaning the payload width in bits (minimum 1).
REQ-002 SHALL have parameter CLEAR_MASK [DATA_W-1:0], default all-ones, meaning payload bits forced to 0 in every entry on flush; bits at 0 in the mask hold their value.
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, upstream payload valid.
REQ-006 SHALL have port in_ready, output, 1, stage can accept; driven directly by a register.
REQ-007 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-008 SHALL have port out_valid, output, 1, downstream payload valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts.
REQ-010 SHALL have port out_data, output, DATA_W, downstream payload.
REQ-011 SHALL have port flush, input, 1, discards all held entries.
REQ-012 SHALL have port occupancy, output, 2, number of held entries (0..2).

Function
REQ-013 SHALL define an accept as in_valid && in_ready, and an emit as out_valid && out_ready, both sampled at the same clk edge.
REQ-014 SHALL use exactly three states: EMPTY, ONE (main entry valid) and TWO (main and skid entries valid).
REQ-015 SHALL set out_valid = (state != EMPTY), out_data = main entry, in_ready = (state != TWO), and occupancy equal to the state count.
REQ-016 SHALL have 1-cycle latency: data accepted in EMPTY appears on out_data with out_valid=1 the next cycle.
REQ-017 SHALL transition EMPTY: on accept go to ONE and load main with in_data; otherwise stay in EMPTY.
REQ-018 SHALL transition ONE: on accept and emit stay in ONE and load main with in_data; on accept only go to TWO and load skid with in_data; on emit only go to EMPTY; otherwise hold.
REQ-019 SHALL transition TWO: on emit go to ONE and load main with skid; otherwise hold (no accept is possible).
REQ-020 SHALL sustain one transfer per cycle when out_ready is held at 1, with no bubbles.
REQ-021 SHALL keep out_data and out_valid unchanged while out_valid=1 and out_ready=0, absent flush.
REQ-022 SHALL give flush priority over everything else: next state is EMPTY, occupancy 0, and in_ready 1 in the next cycle.
REQ-023 SHALL discard any accept in the flush cycle, and SHALL count an emit in the flush cycle as completed.
REQ-024 SHALL, on flush, clear the CLEAR_MASK bits of main and skid to 0 and keep the unmasked bits unchanged.
REQ-025 SHALL produce no payload transfer that was never accepted, and SHALL never lose or duplicate an accepted payload absent flush.

Reset
REQ-026 SHALL, while rst=1 at a clk edge, set state to EMPTY and main and skid to all-zero; flush and all handshakes SHALL be ignored.
REQ-027 SHALL drive in_ready=1, out_valid=0, out_data=0 and occupancy=0 from the first edge after rst is asserted, including when reset is asserted mid-stream in state TWO.

Structure
REQ-028 SHALL place the state enumeration (EMPTY/ONE/TWO) and the occupancy-width constant in shared package pipe_pkg.
REQ-029 SHALL implement each entry as sub-module pipe_entry_reg (DATA_W register with load, flush-mask clear and reset), instantiated twice (main, skid).

Verification (DATA_W=16, CLEAR_MASK=16'h00FF)
REQ-030 SHALL cover: reset, then in_data=16'hA501 with in_valid=1 for one cycle -> next cycle out_valid=1, out_data=16'hA501, occupancy=1.
REQ-031 SHALL cover: out_ready=0 while 16'h1111 and then 16'h2222 are offered -> occupancy=2 and in_ready=0; then out_ready=1 -> outputs 1111 then 2222 in order, in_ready=1 after the first emit.
REQ-032 SHALL cover: in_valid=1 and out_ready=1 for 8 cycles with values 0..7 -> out_data=0..7 on consecutive cycles, and occupancy stays 1.
REQ-033 SHALL cover: TWO holding 16'hABCD and 16'h1234, then flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, the skid entry holds 16'h1200, and the offered input is never emitted.
REQ-034 SHALL cover: rst asserted in state TWO -> next cycle in_ready=1, out_valid=0, out_data=16'h0000.
REQ-035 SHALL cover: constrained-random valid/ready/flush for 10k cycles with a scoreboard -> in-order delivery with no loss or duplication between flushes.
